// File: rtl/wb_arbiter_if.sv
// Write-back bus bundle: ALU and load result streams in, register-file
// write port and hazard query out. The arbiter uses the slave modport.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

interface wb_arbiter_if #(
  parameter int WORD_WIDTH     = `WORD_WIDTH,
  parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH,
  parameter int DEPTH          = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                      alu_valid;
  logic                      alu_ready;
  logic [REG_ADDR_WIDTH-1:0] alu_rd;
  logic [WORD_WIDTH-1:0]     alu_data;
  logic                      ld_valid;
  logic                      ld_ready;
  logic [REG_ADDR_WIDTH-1:0] ld_rd;
  logic [WORD_WIDTH-1:0]     ld_data;
  logic                      w_en;
  logic [REG_ADDR_WIDTH-1:0] wa3;
  logic [WORD_WIDTH-1:0]     wd3;
  logic [REG_ADDR_WIDTH-1:0] ra1;
  logic [REG_ADDR_WIDTH-1:0] ra2;
  logic                      pend1;
  logic                      pend2;
  logic [CNT_W-1:0]          fifo_count;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, ra1, ra2,
    input  alu_ready, ld_ready, w_en, wa3, wd3, pend1, pend2, fifo_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, ra1, ra2,
    output alu_ready, ld_ready, w_en, wa3, wd3, pend1, pend2, fifo_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU results win by default, load
// results queue in a small FIFO and take over once they have waited
// STARVE_LIMIT cycles. Pending flags cover the registered write and every
// queued load so decode can stall on read-after-write hazards.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module wb_arbiter #(
  parameter int WORD_WIDTH     = `WORD_WIDTH,
  parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH,
  parameter int DEPTH          = 4,
  parameter int STARVE_LIMIT   = 3
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SV_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [SV_W-1:0]  STARVE_MAX = SV_W'(STARVE_LIMIT);

  logic [REG_ADDR_WIDTH-1:0] fifo_rd_q   [DEPTH];
  logic [WORD_WIDTH-1:0]     fifo_data_q [DEPTH];
  logic [DEPTH-1:0]          occ_q, occ_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [SV_W-1:0]           starve_q, starve_d;
  logic                      w_en_q, w_en_d;
  logic [REG_ADDR_WIDTH-1:0] wa3_q, wa3_d;
  logic [WORD_WIDTH-1:0]     wd3_q, wd3_d;

  logic fifo_empty, starved, alu_ready, ld_ready;
  logic alu_wr, push, pop;
  logic pend1, pend2;

  // Handshake decode; rd==0 transfers are accepted but never written or queued
  always_comb begin
    fifo_empty = (count_q == '0);
    starved    = (starve_q == STARVE_MAX);
    alu_ready  = !(starved && !fifo_empty);
    ld_ready   = (count_q != FULL_CNT);
    alu_wr     = bus.alu_valid && alu_ready && (bus.alu_rd != '0);
    push       = bus.ld_valid && ld_ready && (bus.ld_rd != '0);
    pop        = !alu_wr && !fifo_empty;
  end

  // Next-state: write selection, FIFO bookkeeping and starvation counter
  always_comb begin
    w_en_d   = 1'b0;
    wa3_d    = wa3_q;
    wd3_d    = wd3_q;
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;

    if (alu_wr) begin
      w_en_d = 1'b1;
      wa3_d  = bus.alu_rd;
      wd3_d  = bus.alu_data;
    end else if (pop) begin
      w_en_d = 1'b1;
      wa3_d  = fifo_rd_q[rd_ptr_q];
      wd3_d  = fifo_data_q[rd_ptr_q];
    end

    // push needs not-full and pop needs not-empty, so the slots never coincide
    if (pop) begin
      occ_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      occ_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (!starved) begin
      starve_d = starve_q + SV_W'(1);
    end
  end

  // Control state and the registered write port; reset drops queued loads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      w_en_q   <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      w_en_q   <= w_en_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
    end
  end

  // FIFO payload storage; validity lives in occ_q so no reset is needed here
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= bus.ld_rd;
      fifo_data_q[wr_ptr_q] <= bus.ld_data;
    end
  end

  // Hazard query against the in-flight write and every occupied FIFO slot
  always_comb begin
    pend1 = w_en_q && (wa3_q == bus.ra1);
    pend2 = w_en_q && (wa3_q == bus.ra2);
    for (int i = 0; i < DEPTH; i++) begin
      if (occ_q[i] && (fifo_rd_q[i] == bus.ra1)) pend1 = 1'b1;
      if (occ_q[i] && (fifo_rd_q[i] == bus.ra2)) pend2 = 1'b1;
    end
    pend1 = pend1 && (bus.ra1 != '0);
    pend2 = pend2 && (bus.ra2 != '0);
  end

  assign bus.alu_ready  = alu_ready;
  assign bus.ld_ready   = ld_ready;
  assign bus.w_en       = w_en_q;
  assign bus.wa3        = wa3_q;
  assign bus.wd3        = wd3_q;
  assign bus.pend1      = pend1;
  assign bus.pend2      = pend2;
  assign bus.fifo_count = count_q;
endmodule
